// File: rtl/tejas_pkg.sv
// Shared TEJAS writeback definitions: result-source and load-size encodings,
// trap causes, writeback FSM states, captured load context and alignment helpers.
package tejas_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 4;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE            = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT      = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_WRITE
    } wb_state_e;

    // Load context held while the memory response is outstanding
    typedef struct packed {
        logic       reg_write;
        logic [2:0] funct3;
        logic [1:0] addr;
    } ld_ctx_t;

    // Any funct3 that is not a byte or half access is handled as a word access
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return addr[0];
            default:       return addr != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_LB, F3_LBU: return addr;
            F3_LH, F3_LHU: return {addr[1], 1'b0};
            default:       return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a word-aligned load response
// and sign- or zero-extends it to XLEN bits.
module load_align
    import tejas_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {24'd0, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data = {16'd0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// TEJAS RV32I writeback stage: owns the register-file write port, waits on load
// responses, flags faults. Optional WB_MISALIGN_TRAP_EN traps misaligned loads.
module writeback_unit
    import tejas_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_reg_write,
    input  logic [4:0]         in_rd_addr,
    input  logic [1:0]         in_wb_sel,
    input  logic [2:0]         in_funct3,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_pc_plus4,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_err,
    output logic               rf_we,
    output logic [4:0]         rf_rd_addr,
    output logic [XLEN-1:0]    rf_rd_data,
    output logic               wb_done,
    output logic               trap_valid,
    output logic [CAUSE_W-1:0] trap_cause
);

    localparam int unsigned CNT_W = 8;

    wb_state_e        state;
    ld_ctx_t          ctx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [XLEN-1:0]  load_data;

    assign cnt_inc = cnt + CNT_W'(1);

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (ctx.addr),
        .funct3 (ctx.funct3),
        .data   (load_data)
    );

    // Pulses default low every cycle and are only raised on the edge entering WRITE
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            wb_done    <= 1'b0;
            trap_valid <= 1'b0;
            trap_cause <= CAUSE_NONE;
            cnt        <= '0;
            ctx        <= '0;
        end else begin
            rf_we      <= 1'b0;
            wb_done    <= 1'b0;
            trap_valid <= 1'b0;
            trap_cause <= CAUSE_NONE;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        rf_rd_addr <= in_rd_addr;
                        ctx        <= '{reg_write: in_reg_write,
                                        funct3:    in_funct3,
                                        addr:      force_align(in_funct3, in_alu_result[1:0])};
                        if (in_wb_sel == WB_LOAD) begin
`ifdef WB_MISALIGN_TRAP_EN
                            if (is_misaligned(in_funct3, in_alu_result[1:0])) begin
                                state      <= S_WRITE;
                                wb_done    <= 1'b1;
                                trap_valid <= 1'b1;
                                trap_cause <= CAUSE_LOAD_MISALIGNED;
                            end else begin
                                state <= S_WAIT_MEM;
                                cnt   <= '0;
                            end
`else
                            state <= S_WAIT_MEM;
                            cnt   <= '0;
`endif
                        end else begin
                            state      <= S_WRITE;
                            wb_done    <= 1'b1;
                            rf_we      <= in_reg_write && (in_rd_addr != 5'd0);
                            rf_rd_data <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
                        end
                    end
                end

                // A response in the same cycle as the timeout wins
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state   <= S_WRITE;
                        wb_done <= 1'b1;
                        if (mem_err) begin
                            trap_valid <= 1'b1;
                            trap_cause <= CAUSE_LOAD_FAULT;
                        end else begin
                            rf_we      <= ctx.reg_write && (rf_rd_addr != 5'd0);
                            rf_rd_data <= load_data;
                        end
                    end else if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                        state      <= S_WRITE;
                        wb_done    <= 1'b1;
                        trap_valid <= 1'b1;
                        trap_cause <= CAUSE_LOAD_FAULT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_WRITE: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a per-cycle expectation table built from a
// transaction-level model, checked every cycle, plus literal spot checks.
module tb_writeback_unit;
    import tejas_pkg::*;

    localparam int MEM_TO = 4;

`ifdef WB_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rd_addr = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        wb_done;
    logic        trap_valid;
    logic [3:0]  trap_cause;

    writeback_unit #(.MEM_TIMEOUT(MEM_TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg_write (in_reg_write),
        .in_rd_addr   (in_rd_addr),
        .in_wb_sel    (in_wb_sel),
        .in_funct3    (in_funct3),
        .in_alu_result(in_alu_result),
        .in_pc_plus4  (in_pc_plus4),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .wb_done      (wb_done),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ready;
        logic        done;
        logic        we;
        logic        trap;
        logic [3:0]  cause;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam exp_t IDLE_EXP = '{ready: 1'b1, done: 1'b0, we: 1'b0, trap: 1'b0,
                                  cause: 4'd0, addr: 5'd0, data: 32'd0};

    exp_t exp_q [int];
    exp_t cmp_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
        end
    endtask

    // Loads expressed as shift-and-mask over the response word
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v;
        int unsigned sh;
        case (f3)
            3'b000, 3'b100: begin
                sh = 8 * (a % 4);
                v  = (w >> sh) & 32'h0000_00FF;
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                sh = 16 * ((a / 2) % 2);
                v  = (w >> sh) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        if (f3 == 3'b010) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Every cycle after the first edge the outputs must match the expectation table
    always @(negedge clock) begin
        if (cyc >= 1) begin
            cmp_e = exp_q.exists(cyc) ? exp_q[cyc] : IDLE_EXP;
            check("in_ready",   32'(in_ready),   32'(cmp_e.ready));
            check("wb_done",    32'(wb_done),    32'(cmp_e.done));
            check("rf_we",      32'(rf_we),      32'(cmp_e.we));
            check("trap_valid", 32'(trap_valid), 32'(cmp_e.trap));
            check("trap_cause", 32'(trap_cause), 32'(cmp_e.cause));
            if (cmp_e.we) begin
                check("rf_rd_addr", 32'(rf_rd_addr), 32'(cmp_e.addr));
                check("rf_rd_data", rf_rd_data, cmp_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One instruction from accept to the cycle after its write; delay = idle wait cycles
    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                         input int delay, input logic [31:0] rdata, input logic err,
                         input bit lit_en, input logic [31:0] lit);
        int c, wcyc;
        logic [3:0] cause;
        logic [31:0] data;
        bit wait_mem;
        exp_t e;
        c = cyc;
        in_valid = 1'b1; in_reg_write = rw; in_rd_addr = rd; in_wb_sel = sel;
        in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
        tick();
        in_wb_sel = 2'($urandom); in_rd_addr = 5'($urandom); in_funct3 = 3'($urandom);
        in_alu_result = $urandom; in_pc_plus4 = $urandom; in_reg_write = 1'($urandom);

        wait_mem = 1'b0;
        cause = 4'd0;
        data = 32'd0;
        if (sel != 2'd1) begin
            data = (sel == 2'd2) ? pc4 : alu;
            wcyc = c + 1;
        end else if (TRAP_EN && model_misaligned(alu, f3)) begin
            cause = 4'd4;
            wcyc = c + 1;
        end else begin
            wait_mem = 1'b1;
            if (delay >= MEM_TO) begin
                cause = 4'd5;
                wcyc = c + 1 + MEM_TO;
            end else begin
                wcyc = c + 2 + delay;
                cause = err ? 4'd5 : 4'd0;
                data = model_load(rdata, alu, f3);
            end
        end

        for (int k = c + 1; k < wcyc; k++) begin
            e = IDLE_EXP;
            e.ready = 1'b0;
            exp_q[k] = e;
        end
        e.ready = 1'b0;
        e.done = 1'b1;
        e.trap = (cause != 4'd0);
        e.cause = cause;
        e.we = rw && (rd != 5'd0) && (cause == 4'd0);
        e.addr = rd;
        e.data = data;
        exp_q[wcyc] = e;

        if (wait_mem && delay < MEM_TO) begin
            repeat (delay) tick();
            mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
            tick();
            mem_rvalid = 1'b0; mem_rdata = $urandom; mem_err = 1'b0;
        end
        while (cyc < wcyc) tick();
        @(negedge clock);
        if (lit_en) check("literal_rf_rd_data", rf_rd_data, lit);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        exp_t e;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check("reset_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
        check("reset_rf_rd_data", rf_rd_data, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        check("model_lb",  model_load(32'h80FF_0000, 32'h3, 3'b000), 32'hFFFF_FF80);
        check("model_lbu", model_load(32'h80FF_0000, 32'h3, 3'b100), 32'h0000_0080);
        check("model_lh",  model_load(32'h8001_7FFF, 32'h2, 3'b001), 32'hFFFF_8001);

        issue(1, 5'd5, WB_ALU, 3'd0, 32'h1234_5678, 32'h0, 0, 32'h0, 0, 1, 32'h1234_5678);
        issue(1, 5'd6, WB_LOAD, F3_LB,  32'h0000_1003, 32'h0, 3, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80);
        issue(1, 5'd7, WB_LOAD, F3_LBU, 32'h0000_1003, 32'h0, 3, 32'h80FF_0000, 0, 1, 32'h0000_0080);
        issue(1, 5'd0, WB_ALU, 3'd0, 32'hDEAD_0000, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        issue(1, 5'd1, WB_PC4, 3'd0, 32'hAAAA_AAAA, 32'h0000_0104, 0, 32'h0, 0, 1, 32'h0000_0104);
        issue(0, 5'd9, WB_ALU, 3'd0, 32'h5555_5555, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        issue(1, 5'd10, 2'd3, 3'd0, 32'h0BAD_CAFE, 32'h1111_1111, 0, 32'h0, 0, 1, 32'h0BAD_CAFE);
`ifdef WB_MISALIGN_TRAP_EN
        issue(1, 5'd11, WB_LOAD, F3_LW, 32'h0000_2002, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        issue(1, 5'd12, WB_LOAD, F3_LHU, 32'h0000_2001, 32'h0, 1, 32'h8001_7FFF, 0, 0, 32'h0);
`else
        issue(1, 5'd11, WB_LOAD, F3_LW, 32'h0000_2002, 32'h0, 1, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
        issue(1, 5'd12, WB_LOAD, F3_LHU, 32'h0000_2001, 32'h0, 1, 32'h8001_7FFF, 0, 1, 32'h0000_7FFF);
`endif
        issue(1, 5'd13, WB_LOAD, F3_LH,  32'h0000_3002, 32'h0, 2, 32'h8001_7FFF, 0, 1, 32'hFFFF_8001);
        issue(1, 5'd14, WB_LOAD, F3_LHU, 32'h0000_3000, 32'h0, 0, 32'h8001_7FFF, 0, 1, 32'h0000_7FFF);
        issue(1, 5'd15, WB_LOAD, F3_LB,  32'h0000_3001, 32'h0, 1, 32'h1234_7F00, 0, 1, 32'h0000_007F);
        issue(1, 5'd16, WB_LOAD, F3_LW,  32'h0000_3004, 32'h0, 0, 32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D);
        issue(1, 5'd17, WB_LOAD, 3'b011, 32'h0000_3008, 32'h0, 2, 32'h0102_0304, 0, 1, 32'h0102_0304);
        issue(1, 5'd18, WB_LOAD, F3_LW,  32'h0000_4000, 32'h0, MEM_TO - 1, 32'h7777_8888, 0, 1, 32'h7777_8888);
        issue(1, 5'd19, WB_LOAD, F3_LW,  32'h0000_4000, 32'h0, 10, 32'h0, 0, 0, 32'h0);
        issue(1, 5'd20, WB_LOAD, F3_LW,  32'h0000_4000, 32'h0, 2, 32'h9999_9999, 1, 0, 32'h0);

        // Reset while waiting on memory, then a late response that must be ignored
        c = cyc;
        in_valid = 1'b1; in_reg_write = 1'b1; in_rd_addr = 5'd21; in_wb_sel = WB_LOAD;
        in_funct3 = F3_LW; in_alu_result = 32'h0000_5000;
        tick();
        in_valid = 1'b0;
        e = IDLE_EXP;
        e.ready = 1'b0;
        exp_q[c + 1] = e;
        exp_q[c + 2] = e;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hFEED_FACE;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clock);
        check("post_reset_rf_we", 32'(rf_we), 32'd0);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        issue(1, 5'd22, WB_ALU, 3'd0, 32'h0000_00AB, 32'h0, 0, 32'h0, 0, 1, 32'h0000_00AB);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
